// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: takes a WIDTH-bit word over valid/ready and
// emits it one bit per shift_en cycle on ser_out, qualified by ser_valid.
module bit_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift_en,
   input  logic             flush,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t           r_state,      w_state_nxt;
   logic [WIDTH-1:0] r_shreg,      w_shreg_nxt;
   logic [CW-1:0]    r_cnt,        w_cnt_nxt;
   logic             r_ser_out,    w_ser_out_nxt;
   logic             r_ser_valid,  w_ser_valid_nxt;
   logic             r_done,       w_done_nxt;
   logic             r_busy,       w_busy_nxt;
   logic             r_load_ready, w_load_ready_nxt;
   logic             w_next_bit;
   logic [WIDTH-1:0] w_shreg_shifted;

   assign w_next_bit      = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
   assign w_shreg_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                      : {1'b0, r_shreg[WIDTH-1:1]};

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_shreg      <= '0;
         r_cnt        <= '0;
         r_ser_out    <= 1'b0;
         r_ser_valid  <= 1'b0;
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
         r_load_ready <= 1'b1;
      end else begin
         r_state      <= w_state_nxt;
         r_shreg      <= w_shreg_nxt;
         r_cnt        <= w_cnt_nxt;
         r_ser_out    <= w_ser_out_nxt;
         r_ser_valid  <= w_ser_valid_nxt;
         r_done       <= w_done_nxt;
         r_busy       <= w_busy_nxt;
         r_load_ready <= w_load_ready_nxt;
      end
   end

   // Next-state and next-output logic; flush wins over everything else
   always_comb begin
      w_state_nxt     = r_state;
      w_shreg_nxt     = r_shreg;
      w_cnt_nxt       = r_cnt;
      w_ser_out_nxt   = r_ser_out;
      w_ser_valid_nxt = 1'b0;
      w_done_nxt      = 1'b0;

      if (flush) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (load_valid) begin
                  w_shreg_nxt = load_data;
                  w_cnt_nxt   = CW'(WIDTH);
                  w_state_nxt = S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (shift_en) begin
                  w_ser_out_nxt   = w_next_bit;
                  w_ser_valid_nxt = 1'b1;
                  w_shreg_nxt     = w_shreg_shifted;
                  w_cnt_nxt       = (r_cnt != '0) ? r_cnt - CW'(1) : '0;
                  if (r_cnt == CW'(1)) begin
                     w_done_nxt  = 1'b1;
                     w_state_nxt = S_IDLE;
                  end
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end

      // Ready is registered, so it reflects the state being entered
      w_load_ready_nxt = (w_state_nxt == S_IDLE);
      w_busy_nxt       = (w_state_nxt == S_SHIFT);
   end

   assign load_ready = r_load_ready;
   assign ser_out    = r_ser_out;
   assign ser_valid  = r_ser_valid;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: MSB-first and LSB-first instances share
// stimulus; expected bit streams are queued at each handshake.
module tb_bit_serializer;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         load_valid;
   logic [W-1:0] load_data;
   logic         shift_en;
   logic         flush;
   logic         so [2];
   logic         sv [2];
   logic         dn [2];
   logic         lr [2];
   logic         by [2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic b;
      logic last;
      int   cyc;
   } exp_t;

   exp_t q_msb [$];
   exp_t q_lsb [$];
   logic last_bit [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(lr[0]),
      .load_data(load_data), .shift_en(shift_en), .flush(flush),
      .ser_out(so[0]), .ser_valid(sv[0]), .busy(by[0]), .done(dn[0]));

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(lr[1]),
      .load_data(load_data), .shift_en(shift_en), .flush(flush),
      .ser_out(so[1]), .ser_valid(sv[1]), .busy(by[1]), .done(dn[1]));

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   function automatic void mon(input int d);
      exp_t e;
      int   n;
      n = (d == 0) ? q_msb.size() : q_lsb.size();
      if (sv[d]) begin
         if (n == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ser_valid[%0d]: got 1 want 0 (t=%0t)", d, $time);
         end else begin
            e = (d == 0) ? q_msb.pop_front() : q_lsb.pop_front();
            chk($sformatf("ser_out[%0d]", d), 32'(so[d]), 32'(e.b));
            chk($sformatf("done[%0d]", d), 32'(dn[d]), 32'(e.last));
            if (e.cyc >= 0) chk($sformatf("bit_cycle[%0d]", d), 32'(cyc), 32'(e.cyc));
         end
         last_bit[d] = so[d];
      end else begin
         chk($sformatf("done_no_valid[%0d]", d), 32'(dn[d]), 32'd0);
         chk($sformatf("ser_out_hold[%0d]", d), 32'(so[d]), 32'(last_bit[d]));
      end
   endfunction

   // Monitor: compare every presented bit against the scoreboard
   always @(negedge clk) begin
      if (!reset) begin
         last_bit[0] = 1'b0;
         last_bit[1] = 1'b0;
      end else begin
         for (int d = 0; d < 2; d++) mon(d);
      end
   end

   // Reference: bit i of the stream is word[W-1-i] (MSB first) or word[i]
   task automatic push_exp(input logic [W-1:0] w, input int n, input int hcyc, input bit timed);
      for (int i = 0; i < n; i++) begin
         q_msb.push_back('{w[W-1-i], (i == W-1), timed ? hcyc + i + 2 : -1});
         q_lsb.push_back('{w[i],     (i == W-1), timed ? hcyc + i + 2 : -1});
      end
   endtask

   task automatic handshake(input logic [W-1:0] w, output int hcyc, output bit ok);
      load_valid = 1'b1;
      load_data  = w;
      ok   = 1'b0;
      hcyc = -1;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = lr[0] && !flush;
         @(posedge clk);
         hcyc = cyc;
      end
      #1;
      load_valid = 1'b0;
      load_data  = 'x;
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL handshake_timeout: got no accept want accept");
      end
   endtask

   // mode 0: shift_en=1, 1: pattern 1,0,0, 2: random; n<W aborts with flush
   task automatic xfer(input logic [W-1:0] w, input int mode, input int n,
                       input bit hold_next, input logic [W-1:0] nxt, output int hcyc);
      bit ok;
      int k;
      int ph;
      shift_en = (mode == 0);
      handshake(w, hcyc, ok);
      if (!ok) return;
      push_exp(w, n, hcyc, mode == 0);
      if (hold_next) begin
         load_valid = 1'b1;
         load_data  = nxt;
      end
      chk("busy_after_load", 32'(by[0]), 32'd1);
      chk("ready_after_load", 32'(lr[1]), 32'd0);
      k  = 0;
      ph = 0;
      while (k < n && ph < 1000) begin
         case (mode)
            0:       shift_en = 1'b1;
            1:       shift_en = (ph % 3 == 0);
            default: shift_en = 1'($urandom % 2);
         endcase
         ph++;
         @(posedge clk);
         if (shift_en) k++;
         #1;
      end
      if (n < W) begin
         flush    = 1'b1;
         shift_en = 1'b1;
         @(posedge clk);
         #1;
         flush = 1'b0;
      end
      chk("ready_after_word[0]", 32'(lr[0]), 32'd1);
      chk("ready_after_word[1]", 32'(lr[1]), 32'd1);
      chk("busy_after_word", 32'(by[1]), 32'd0);
   endtask

   initial begin
      int  h;
      int  h2;
      bit  ok;
      int  mode;
      int  n;
      reset      = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      shift_en   = 1'b0;
      flush      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_ready", 32'(lr[d]), 32'd1);
         chk("rst_valid", 32'(sv[d]), 32'd0);
         chk("rst_busy",  32'(by[d]), 32'd0);
         chk("rst_done",  32'(dn[d]), 32'd0);
         chk("rst_out",   32'(so[d]), 32'd0);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;

      xfer(8'hB4, 0, W, 1'b0, '0, h);
      xfer(8'hB4, 1, W, 1'b0, '0, h);
      xfer(8'hA5, 0, 3, 1'b0, '0, h);
      repeat (4) @(posedge clk);
      #1;
      xfer(8'h0F, 0, W, 1'b0, '0, h);

      // Asynchronous reset between edges, mid-word
      shift_en = 1'b1;
      handshake(8'hC3, h, ok);
      if (ok) push_exp(8'hC3, 3, h, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("async_rst_out",   32'(so[d]), 32'd0);
         chk("async_rst_valid", 32'(sv[d]), 32'd0);
         chk("async_rst_busy",  32'(by[d]), 32'd0);
         chk("async_rst_ready", 32'(lr[d]), 32'd1);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      xfer(8'h96, 0, W, 1'b0, '0, h);

      // Back-to-back with load_valid held through the busy period
      xfer(8'hB4, 0, W, 1'b1, 8'h4B, h);
      xfer(8'h4B, 0, W, 1'b0, '0, h2);
      chk("b2b_gap", 32'(h2 - h), 32'(W + 1));

      for (int i = 0; i < 20; i++) begin
         mode = int'($urandom % 3);
         n    = ($urandom % 4 == 0) ? 1 + int'($urandom % (W - 1)) : W;
         xfer(W'($urandom), mode, n, 1'b0, '0, h);
         if ($urandom % 2 == 1) begin
            repeat (1 + $urandom % 3) @(posedge clk);
            #1;
         end
      end

      shift_en = 1'b0;
      repeat (6) @(posedge clk);
      chk("q_msb_empty", 32'(q_msb.size()), 32'd0);
      chk("q_lsb_empty", 32'(q_lsb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
